// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: controller state encoding.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/half_sub_cell.sv
// Half subtractor: single-bit a - b with borrow-out.
module half_sub_cell (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  // Difference is the XOR; a borrow is needed only when subtracting 1 from 0.
  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule : half_sub_cell

// File: rtl/serial_sub_unit.sv
// Bit-serial N-bit subtractor: out_diff = in_a - in_b, one bit per clock,
// LSB first. Operands enter and results leave through val/rdy handshakes.
module serial_sub_unit
  import serial_sub_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_diff,
  output logic             out_borrow
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  state_t           state;
  state_t           next_state;
  logic [NBITS-1:0] a_reg;
  logic [NBITS-1:0] b_reg;
  logic [NBITS-1:0] diff_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt;

  logic             last_bit;
  logic             accept;
  logic             release_out;

  // Full-subtract step built from two half subtractors.
  logic             hs0_diff;
  logic             hs0_borrow;
  logic             diff_bit;
  logic             hs1_borrow;
  logic             borrow_next;

  // First cell: minuend bit minus subtrahend bit.
  half_sub_cell u_hs0 (
    .a      (a_reg[0]),
    .b      (b_reg[0]),
    .diff   (hs0_diff),
    .borrow (hs0_borrow)
  );

  // Second cell: partial difference minus the incoming borrow.
  half_sub_cell u_hs1 (
    .a      (hs0_diff),
    .b      (borrow_reg),
    .diff   (diff_bit),
    .borrow (hs1_borrow)
  );

  // The two borrow conditions are mutually exclusive, so OR combines them.
  assign borrow_next = hs0_borrow | hs1_borrow;

  assign last_bit    = (cnt == LAST_CNT);
  assign accept      = (state == IDLE) && in_val;
  assign release_out = (state == DONE) && out_rdy;

  // Handshake outputs decode directly from state; results come from registers.
  assign in_rdy     = (state == IDLE);
  assign out_val    = (state == DONE);
  assign out_diff   = diff_reg;
  assign out_borrow = borrow_reg;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: accept in IDLE, run NBITS steps, hold result until taken.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)      next_state = CALC;
      CALC:    if (last_bit)    next_state = DONE;
      DONE:    if (release_out) next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, borrow chain and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            borrow_reg <= 1'b0;
            cnt        <= '0;
          end
        end
        CALC: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          diff_reg   <= {diff_bit, diff_reg[NBITS-1:1]};
          borrow_reg <= borrow_next;
          // Counter parks on the final index; the next accept clears it.
          if (!last_bit) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : serial_sub_unit
